rx_pwm2_decoder: RTL and testbench



---
 rtl/rx_pwm2_decoder_pkg.sv | 18 +
 rtl/rx_pwm2_decoder_edge_sync.sv | 27 ++
 rtl/rx_pwm2_decoder.sv | 172 +++++++++++++++++
 tb/tb_rx_pwm2_decoder.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/rx_pwm2_decoder_pkg.sv
// Shared types and elaboration helpers for the 2-level PWM receive path.
package pwm2_pkg;

    typedef enum logic [1:0] {
        ACQ,
        TRAIN,
        LOCK
    } state_t;

    localparam int CODE_W = 4;

    // A frame must hold all 16 code positions.
    function automatic logic frame_cyc_ok(input int unsigned frame_cyc,
                                          input int unsigned unit_shift);
        return frame_cyc >= (32'd16 << unit_shift);
    endfunction

endpackage

// File: rtl/rx_pwm2_decoder_edge_sync.sv
// Two-flop synchronizer on the sliced line plus a history flop; flags either edge polarity.
module pwm_edge_sync (
    input  logic clk,
    input  logic rstn,
    input  logic din,
    output logic edge_det
);

    logic sync1;
    logic sync2;
    logic prev;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
        end else begin
            sync1 <= din;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign edge_det = sync2 ^ prev;

endmodule

// File: rtl/rx_pwm2_decoder.sv
// Frame alignment, code recovery and error tracking for the 2-level PWM receiver.
module rx_pwm2_decoder
    import pwm2_pkg::*;
#(
    parameter int UNIT_SHIFT = 2,
    parameter int FRAME_CYC  = 80,
    parameter int TRAIN_LEN  = 8,
    parameter int MAX_MISS   = 4
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              din,
    input  logic              err_clr,
    output logic [CODE_W-1:0] code,
    output logic              code_valid,
    output logic              locked,
    output logic              err,
    output logic [7:0]        err_cnt
);

    localparam int U  = 1 << UNIT_SHIFT;
    localparam int H  = U / 2;
    localparam int CW = $clog2(FRAME_CYC);
    localparam int IW = $clog2(2 * FRAME_CYC);
    localparam int TW = $clog2(TRAIN_LEN + 1);
    localparam int MW = $clog2(MAX_MISS + 1);

    localparam logic [CW-1:0] CNT_LAST  = CW'(FRAME_CYC - 1);
    localparam logic [CW-1:0] TRAIN_LO  = CW'(FRAME_CYC - H);
    localparam logic [CW-1:0] TRAIN_HI  = CW'(H);
    localparam logic [CW-1:0] DATA_HI   = CW'(15 * U + H - 1);
    localparam logic [IW-1:0] IDLE_LAST = IW'(2 * FRAME_CYC - 1);
    localparam logic [TW-1:0] TRAIN_END = TW'(TRAIN_LEN - 1);
    localparam logic [MW-1:0] MISS_END  = MW'(MAX_MISS - 1);

    if (!frame_cyc_ok(FRAME_CYC, UNIT_SHIFT)) begin : g_bad_frame
        $error("rx_pwm2_decoder: FRAME_CYC must be at least 16 Tunits");
    end

    logic edge_det;

    pwm_edge_sync u_edge_sync (
        .clk      (clk),
        .rstn     (rstn),
        .din      (din),
        .edge_det (edge_det)
    );

    state_t            state;
    logic [CW-1:0]     cnt;
    logic [IW-1:0]     idle_cnt;
    logic [TW-1:0]     train_cnt;
    logic [MW-1:0]     miss_cnt;
    logic              frame_seen;
    logic              frame_bad;
    logic              dec_pend;
    logic [CODE_W-1:0] dec_code;

    logic [CW-1:0]     cnt_next;
    logic              in_train_win;
    logic              in_data_win;
    logic [CW:0]       dec_sum;
    logic [CW:0]       dec_shift;
    logic [CODE_W-1:0] code_calc;
    logic              good_edge;
    logic              seen_now;
    logic              bad_now;

    always_comb begin
        cnt_next     = (cnt == CNT_LAST) ? '0 : cnt + CW'(1);
        in_train_win = (cnt >= TRAIN_LO) || (cnt <= TRAIN_HI);
        in_data_win  = (cnt <= DATA_HI);
        dec_sum      = {1'b0, cnt} + (CW + 1)'(H);
        dec_shift    = dec_sum >> UNIT_SHIFT;
        code_calc    = (dec_shift > (CW + 1)'(15)) ? CODE_W'(15) : dec_shift[CODE_W-1:0];
        good_edge    = edge_det && !frame_seen && in_data_win;
        seen_now     = frame_seen || edge_det;
        bad_now      = frame_bad || (edge_det && !good_edge);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= ACQ;
            cnt        <= '0;
            idle_cnt   <= '0;
            train_cnt  <= '0;
            miss_cnt   <= '0;
            frame_seen <= 1'b0;
            frame_bad  <= 1'b0;
            dec_pend   <= 1'b0;
            dec_code   <= '0;
            code       <= '0;
            code_valid <= 1'b0;
            locked     <= 1'b0;
            err        <= 1'b0;
            err_cnt    <= '0;
        end else begin
            code_valid <= dec_pend;
            if (dec_pend) begin
                code <= dec_code;
            end
            dec_pend <= 1'b0;
            err      <= 1'b0;

            if (err_clr) begin
                err_cnt <= err ? 8'd1 : 8'd0;
            end else if (err && (err_cnt != 8'hFF)) begin
                err_cnt <= err_cnt + 8'd1;
            end

            cnt <= cnt_next;
            case (state)
                ACQ: begin
                    if (edge_det) begin
                        cnt       <= CW'(1);
                        train_cnt <= '0;
                        idle_cnt  <= '0;
                        state     <= TRAIN;
                    end
                end
                TRAIN: begin
                    idle_cnt <= idle_cnt + IW'(1);
                    if (edge_det) begin
                        cnt      <= CW'(1);
                        idle_cnt <= '0;
                        if (!in_train_win) begin
                            train_cnt <= '0;
                        end else if (train_cnt == TRAIN_END) begin
                            // The locking edge belongs to the first LOCK frame, so that frame is not edgeless.
                            state      <= LOCK;
                            locked     <= 1'b1;
                            miss_cnt   <= '0;
                            frame_seen <= 1'b1;
                            frame_bad  <= 1'b0;
                        end else begin
                            train_cnt <= train_cnt + TW'(1);
                        end
                    end else if (idle_cnt == IDLE_LAST) begin
                        state <= ACQ;
                    end
                end
                LOCK: begin
                    if (good_edge) begin
                        dec_pend <= 1'b1;
                        dec_code <= code_calc;
                    end
                    if (cnt == CNT_LAST) begin
                        frame_seen <= 1'b0;
                        frame_bad  <= 1'b0;
                        if (bad_now || !seen_now) begin
                            err <= 1'b1;
                            if (miss_cnt == MISS_END) begin
                                state    <= ACQ;
                                locked   <= 1'b0;
                                miss_cnt <= '0;
                            end else begin
                                miss_cnt <= miss_cnt + MW'(1);
                            end
                        end else begin
                            miss_cnt <= '0;
                        end
                    end else begin
                        frame_seen <= seen_now;
                        frame_bad  <= bad_now;
                    end
                end
                default: state <= ACQ;
            endcase
        end
    end

endmodule

// File: tb/tb_rx_pwm2_decoder.sv
// Directed bench for rx_pwm2_decoder; toggles are placed on a frame grid anchored at an alignment toggle.
module tb_rx_pwm2_decoder;

    logic       clk = 1'b0;
    logic       rstn;
    logic       din;
    logic       err_clr;
    logic [3:0] code;
    logic       code_valid;
    logic       locked;
    logic       err;
    logic [7:0] err_cnt;

    rx_pwm2_decoder #(
        .UNIT_SHIFT (2),
        .FRAME_CYC  (80),
        .TRAIN_LEN  (8),
        .MAX_MISS   (4)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .din        (din),
        .err_clr    (err_clr),
        .code       (code),
        .code_valid (code_valid),
        .locked     (locked),
        .err        (err),
        .err_cnt    (err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int off;
        int exp_code;
    } vec_t;

    vec_t vecs[8];
    int   t;
    int   base;
    int   n_pass;
    int   n_chk;
    int   cv_cnt;
    int   err_pulses;
    int   snap;

    task automatic chk(input string name, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0d)", name, got, exp, t);
    endtask

    task automatic step();
        @(negedge clk);
        t++;
        if (code_valid) cv_cnt++;
        if (err) err_pulses++;
    endtask

    task automatic upto(input int x);
        while (t < x) step();
    endtask

    task automatic tog_at(input int x);
        upto(x);
        din = ~din;
    endtask

    function automatic int pos(input int f, input int off);
        return base + 80 * f + off;
    endfunction

    task automatic train_and_lock(input string tag);
        din  = ~din;
        base = t;
        for (int k = 1; k <= 8; k++) tog_at(pos(k, 0));
        upto(pos(8, 2));
        chk({tag, "_locked_before"}, int'(locked), 0);
        step();
        chk({tag, "_locked_after"}, int'(locked), 1);
    endtask

    initial begin
        rstn = 1'b0; din = 1'b0; err_clr = 1'b0;
        t = 0; base = 0; n_pass = 0; n_chk = 0; cv_cnt = 0; err_pulses = 0;
        vecs[0] = '{20, 5};  vecs[1] = '{21, 5};  vecs[2] = '{22, 6};  vecs[3] = '{60, 15};
        vecs[4] = '{0, 0};   vecs[5] = '{2, 1};   vecs[6] = '{5, 1};   vecs[7] = '{6, 2};

        repeat (3) step();
        chk("rst_code", int'(code), 0);
        chk("rst_code_valid", int'(code_valid), 0);
        chk("rst_locked", int'(locked), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_err_cnt", int'(err_cnt), 0);
        rstn = 1'b1;
        repeat (5) step();

        train_and_lock("train1");
        chk("no_code_in_train", cv_cnt, 0);
        chk("no_err_in_train", err_pulses, 0);

        for (int i = 0; i < 8; i++) begin
            int x;
            x = pos(9 + i, vecs[i].off);
            tog_at(x);
            upto(x + 3);
            chk("cv_early", int'(code_valid), 0);
            step();
            chk("cv_pulse", int'(code_valid), 1);
            chk("code_value", int'(code), vecs[i].exp_code);
            step();
            chk("cv_one_cycle", int'(code_valid), 0);
            chk("code_hold", int'(code), vecs[i].exp_code);
        end
        upto(pos(16, 82));
        chk("no_err_good_frames", err_pulses, 0);

        // Frame 17 edgeless.
        upto(pos(17, 81));
        chk("edgeless_err_before", int'(err), 0);
        step();
        chk("edgeless_err", int'(err), 1);
        step();
        chk("edgeless_err_one_cycle", int'(err), 0);
        chk("edgeless_err_cnt", int'(err_cnt), 1);
        chk("edgeless_still_locked", int'(locked), 1);

        // Frame 18: two edges, first one decodes.
        snap = cv_cnt;
        tog_at(pos(18, 8));
        upto(pos(18, 12));
        chk("double_cv", int'(code_valid), 1);
        chk("double_code", int'(code), 2);
        tog_at(pos(18, 40));
        upto(pos(18, 82));
        chk("double_err", int'(err), 1);
        chk("double_single_cv", cv_cnt - snap, 1);
        step();
        chk("double_err_cnt", int'(err_cnt), 2);

        // Frame 19 good, frame 20 edge out of window, frame 21 good.
        tog_at(pos(19, 20));
        upto(pos(19, 82));
        chk("good19_no_err", int'(err), 0);
        snap = cv_cnt;
        tog_at(pos(20, 62));
        upto(pos(20, 82));
        chk("oow_err", int'(err), 1);
        chk("oow_no_cv", cv_cnt - snap, 0);
        tog_at(pos(21, 20));
        upto(pos(21, 82));
        chk("good21_no_err", int'(err), 0);

        // Frames 22..25 edgeless: fourth miss drops lock.
        upto(pos(25, 81));
        chk("miss3_locked", int'(locked), 1);
        step();
        chk("miss4_unlocked", int'(locked), 0);
        chk("miss4_err", int'(err), 1);
        step();
        chk("miss4_err_cnt", int'(err_cnt), 7);

        // Training disrupted by an edge at off 40.
        upto(t + 20);
        din  = ~din;
        base = t;
        for (int k = 1; k <= 3; k++) tog_at(pos(k, 0));
        tog_at(pos(3, 40));
        base = base + 280;
        for (int k = 1; k <= 8; k++) begin
            tog_at(pos(k, 0));
            if (k == 7) begin
                upto(pos(7, 3));
                chk("disrupt_not_locked_7", int'(locked), 0);
            end
        end
        upto(pos(8, 2));
        chk("disrupt_locked_before", int'(locked), 0);
        step();
        chk("disrupt_locked_after", int'(locked), 1);

        // Saturation: groups of three edgeless frames then one good frame.
        snap = err_pulses;
        for (int g = 0; g < 83; g++) tog_at(pos(9 + 4 * g + 3, 20));
        upto(pos(340, 82));
        chk("sat_err_pulses", err_pulses - snap, 249);
        chk("sat_err_cnt", int'(err_cnt), 255);
        chk("sat_locked", int'(locked), 1);

        // err_clr coinciding with err.
        upto(pos(341, 82));
        chk("clr_err_pulse", int'(err), 1);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("clr_with_err", int'(err_cnt), 1);
        tog_at(pos(342, 20));
        upto(pos(342, 40));
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("clr_plain", int'(err_cnt), 0);

        // Reset mid-LOCK.
        upto(pos(344, 30));
        chk("pre_rst_code", int'(code), 5);
        chk("pre_rst_err_cnt", int'(err_cnt), 1);
        chk("pre_rst_locked", int'(locked), 1);
        #1 rstn = 1'b0;
        din = 1'b0;
        #1;
        chk("async_rst_code", int'(code), 0);
        chk("async_rst_locked", int'(locked), 0);
        chk("async_rst_err_cnt", int'(err_cnt), 0);
        chk("async_rst_cv", int'(code_valid), 0);
        chk("async_rst_err", int'(err), 0);
        repeat (3) step();
        rstn = 1'b1;
        repeat (5) step();
        train_and_lock("post_rst");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
